// File: rtl/softmax_sequencer_if.sv
// Handshake bundle between the softmax sequencer and its shared FP32
// exp / add / div units, plus the outgoing probability stream.
//   master : sequencer side (drives operands and probabilities, reads results)
//   slave  : unit / consumer side
interface softmax_sequencer_if #(
  parameter int DW = 32
);
  logic          exp_op_valid;
  logic [DW-1:0] exp_op_data;
  logic          exp_res_valid;
  logic [DW-1:0] exp_res_data;
  logic          add_op_valid;
  logic [DW-1:0] add_op_a;
  logic [DW-1:0] add_op_b;
  logic          add_res_valid;
  logic [DW-1:0] add_res_data;
  logic          div_op_valid;
  logic [DW-1:0] div_op_a;
  logic [DW-1:0] div_op_b;
  logic          div_res_valid;
  logic [DW-1:0] div_res_data;
  logic          out_valid;
  logic [3:0]    out_index;
  logic [DW-1:0] out_data;

  modport master (
    output exp_op_valid, exp_op_data, add_op_valid, add_op_a, add_op_b,
           div_op_valid, div_op_a, div_op_b, out_valid, out_index, out_data,
    input  exp_res_valid, exp_res_data, add_res_valid, add_res_data,
           div_res_valid, div_res_data
  );

  modport slave (
    input  exp_op_valid, exp_op_data, add_op_valid, add_op_a, add_op_b,
           div_op_valid, div_op_a, div_op_b, out_valid, out_index, out_data,
    output exp_res_valid, exp_res_data, add_res_valid, add_res_data,
           div_res_valid, div_res_data
  );
endinterface

// File: rtl/softmax_sequencer.sv
// Softmax sequencer: runs an N-class softmax through one shared exp unit,
// one shared adder and one shared divider, one operation in flight at a time.
// Ports:
//   i_clock    rising-edge clock
//   i_reset    synchronous, active-low
//   i_start    begin a frame (sampled only in IDLE)
//   i_in_data  logits, class i at [i*DATAWIDTH +: DATAWIDTH]
//   o_busy     frame in progress
//   o_done     one-cycle pulse after the last probability
//   sif        unit handshakes and probability stream (master side)
//
// state      | meaning
// IDLE       | waiting for start
// EXP_ISSUE  | exp operand for idx on the bus
// EXP_WAIT   | waiting for exp result, stored to e_buf[idx]
// ACC_ISSUE  | add(sum, e[idx]) on the bus
// ACC_WAIT   | waiting for adder result, stored to sum
// DIV_ISSUE  | div(e[idx], sum) on the bus
// DIV_WAIT   | waiting for divider result, streamed out
// DONE       | frame finished, pulse done
module softmax_sequencer #(
  parameter int DATAWIDTH   = 32,
  parameter int NUM_CLASSES = 10
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_start,
  input  logic [NUM_CLASSES*DATAWIDTH-1:0] i_in_data,
  output logic                             o_busy,
  output logic                             o_done,
  softmax_sequencer_if.master              sif
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_EXP_ISSUE = 3'd1;
  localparam logic [2:0] S_EXP_WAIT  = 3'd2;
  localparam logic [2:0] S_ACC_ISSUE = 3'd3;
  localparam logic [2:0] S_ACC_WAIT  = 3'd4;
  localparam logic [2:0] S_DIV_ISSUE = 3'd5;
  localparam logic [2:0] S_DIV_WAIT  = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [3:0] IDX_LAST = 4'(NUM_CLASSES - 1);

  logic [2:0]           r_state;
  logic [3:0]           r_idx;
  logic [DATAWIDTH-1:0] r_sum;
  logic [DATAWIDTH-1:0] r_logit [NUM_CLASSES];
  logic [DATAWIDTH-1:0] r_ebuf  [NUM_CLASSES];
  logic                 r_busy, r_done;
  logic                 r_exp_op_valid, r_add_op_valid, r_div_op_valid;
  logic [DATAWIDTH-1:0] r_exp_op_data, r_add_op_a, r_add_op_b, r_div_op_a, r_div_op_b;
  logic                 r_out_valid;
  logic [3:0]           r_out_index;
  logic [DATAWIDTH-1:0] r_out_data;
  logic [3:0]           w_idx_next;

  assign w_idx_next = r_idx + 4'd1;

  // Results are captured and the next op is issued on the same edge, so an
  // op costs 1+L cycles. Only the first exp op of a frame is launched from
  // EXP_ISSUE itself, one cycle after the logits are latched.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_sum          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_exp_op_valid <= 1'b0;
      r_add_op_valid <= 1'b0;
      r_div_op_valid <= 1'b0;
      r_exp_op_data  <= '0;
      r_add_op_a     <= '0;
      r_add_op_b     <= '0;
      r_div_op_a     <= '0;
      r_div_op_b     <= '0;
      r_out_valid    <= 1'b0;
      r_out_index    <= '0;
      r_out_data     <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_logit[i] <= '0;
        r_ebuf[i]  <= '0;
      end
    end else begin
      r_exp_op_valid <= 1'b0;
      r_add_op_valid <= 1'b0;
      r_div_op_valid <= 1'b0;
      r_out_valid    <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              r_logit[i] <= i_in_data[i*DATAWIDTH +: DATAWIDTH];
            r_sum   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_EXP_ISSUE;
          end
        end
        S_EXP_ISSUE: begin
          if (!r_exp_op_valid) begin
            r_exp_op_valid <= 1'b1;
            r_exp_op_data  <= r_logit[r_idx];
          end else begin
            r_state <= S_EXP_WAIT;
          end
        end
        S_EXP_WAIT: begin
          if (sif.exp_res_valid) begin
            r_ebuf[r_idx] <= sif.exp_res_data;
            if (r_idx == IDX_LAST) begin
              r_idx          <= '0;
              r_state        <= S_ACC_ISSUE;
              r_add_op_valid <= 1'b1;
              r_add_op_a     <= r_sum;
              r_add_op_b     <= r_ebuf[0];
            end else begin
              r_idx          <= w_idx_next;
              r_state        <= S_EXP_ISSUE;
              r_exp_op_valid <= 1'b1;
              r_exp_op_data  <= r_logit[w_idx_next];
            end
          end
        end
        S_ACC_ISSUE: r_state <= S_ACC_WAIT;
        S_ACC_WAIT: begin
          if (sif.add_res_valid) begin
            r_sum <= sif.add_res_data;
            if (r_idx == IDX_LAST) begin
              r_idx          <= '0;
              r_state        <= S_DIV_ISSUE;
              r_div_op_valid <= 1'b1;
              r_div_op_a     <= r_ebuf[0];
              r_div_op_b     <= sif.add_res_data;
            end else begin
              r_idx          <= w_idx_next;
              r_state        <= S_ACC_ISSUE;
              r_add_op_valid <= 1'b1;
              r_add_op_a     <= sif.add_res_data;
              r_add_op_b     <= r_ebuf[w_idx_next];
            end
          end
        end
        S_DIV_ISSUE: r_state <= S_DIV_WAIT;
        S_DIV_WAIT: begin
          if (sif.div_res_valid) begin
            r_out_valid <= 1'b1;
            r_out_index <= r_idx;
            r_out_data  <= sif.div_res_data;
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= S_DONE;
            end else begin
              r_idx          <= w_idx_next;
              r_state        <= S_DIV_ISSUE;
              r_div_op_valid <= 1'b1;
              r_div_op_a     <= r_ebuf[w_idx_next];
              r_div_op_b     <= r_sum;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign sif.exp_op_valid = r_exp_op_valid;
  assign sif.exp_op_data  = r_exp_op_data;
  assign sif.add_op_valid = r_add_op_valid;
  assign sif.add_op_a     = r_add_op_a;
  assign sif.add_op_b     = r_add_op_b;
  assign sif.div_op_valid = r_div_op_valid;
  assign sif.div_op_a     = r_div_op_a;
  assign sif.div_op_b     = r_div_op_b;
  assign sif.out_valid    = r_out_valid;
  assign sif.out_index    = r_out_index;
  assign sif.out_data     = r_out_data;
endmodule

// File: tb/tb_softmax_sequencer.sv
module tb_softmax_sequencer;
  localparam int DW = 32;
  localparam int NC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [NC*DW-1:0] in_data = '0;
  logic busy, done;

  softmax_sequencer_if #(.DW(DW)) sif ();

  softmax_sequencer #(.DATAWIDTH(DW), .NUM_CLASSES(NC)) dut (
    .i_clock  (clk),
    .i_reset  (rst_n),
    .i_start  (start),
    .i_in_data(in_data),
    .o_busy   (busy),
    .o_done   (done),
    .sif      (sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // float <-> real, round-to-nearest-even; values here are zero or normal
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else begin
      e = {3'b000, f[30:23]} + 11'd896;
      d = {f[31], e, f[22:0], 29'd0};
    end
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [7:0]  e;
    logic [23:0] m;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = 8'(d[62:52] - 11'd896);
    m = {1'b0, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin e = e + 8'd1; m = '0; end
    return {d[63], e, m[22:0]};
  endfunction

  logic [31:0] SUM_TAB [NC] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                                32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                                32'h41000000, 32'h41100000};

  logic [31:0] x_exp [NC];
  logic [31:0] e_exp [NC];
  logic [31:0] pre_exp [NC];
  logic [31:0] p_exp [NC];
  logic [31:0] tot_exp;
  int  g_real_exp = 0;
  int  g_lat = 3;
  int  g_spur = 0;
  int  g_edge = 0;
  int  t0 = 0;
  int  ek, ak, dk, n_out, n_done, done_e;
  int  out_e [NC];
  real p_sum;
  int  e_cnt = 0, a_cnt = 0, d_cnt = 0;
  logic [31:0] e_pend, a_pend, d_pend;

  task automatic golden_ones();
    g_real_exp = 0;
    for (int i = 0; i < NC; i++) begin
      x_exp[i] = 32'h0; e_exp[i] = 32'h3F800000; pre_exp[i] = SUM_TAB[i];
      p_exp[i] = 32'h3DCCCCCD;
    end
    tot_exp = 32'h41200000;
    in_data = '0;
  endtask

  task automatic golden_model();
    logic [31:0] s;
    g_real_exp = 1;
    s = 32'h0;
    for (int i = 0; i < NC; i++) begin
      x_exp[i] = r2f(real'(i + 1));
      e_exp[i] = r2f($exp(f2r(x_exp[i])));
      pre_exp[i] = s;
      s = r2f(f2r(s) + f2r(e_exp[i]));
      in_data[i*DW +: DW] = x_exp[i];
    end
    tot_exp = s;
    for (int i = 0; i < NC; i++) p_exp[i] = r2f(f2r(e_exp[i]) / f2r(tot_exp));
  endtask

  function automatic int pick_lat();
    return (g_lat == 0) ? int'($urandom_range(1, 8)) : g_lat;
  endfunction

  always @(posedge clk) g_edge++;

  // unit models, spurious strobes and stream monitor
  always @(negedge clk) begin
    int pend;
    int ops;
    sif.exp_res_valid = 1'b0;
    sif.add_res_valid = 1'b0;
    sif.div_res_valid = 1'b0;
    if (e_cnt > 0) begin e_cnt--; if (e_cnt == 0) begin sif.exp_res_valid = 1'b1; sif.exp_res_data = e_pend; end end
    if (a_cnt > 0) begin a_cnt--; if (a_cnt == 0) begin sif.add_res_valid = 1'b1; sif.add_res_data = a_pend; end end
    if (d_cnt > 0) begin d_cnt--; if (d_cnt == 0) begin sif.div_res_valid = 1'b1; sif.div_res_data = d_pend; end end
    if (g_spur != 0) begin
      if (e_cnt == 0 && !sif.exp_res_valid && !sif.exp_op_valid && $urandom_range(0, 2) == 0) begin
        sif.exp_res_valid = 1'b1; sif.exp_res_data = 32'hDEAD0001;
      end
      if (a_cnt == 0 && !sif.add_res_valid && !sif.add_op_valid && $urandom_range(0, 2) == 0) begin
        sif.add_res_valid = 1'b1; sif.add_res_data = 32'hDEAD0002;
      end
      if (d_cnt == 0 && !sif.div_res_valid && !sif.div_op_valid && $urandom_range(0, 2) == 0) begin
        sif.div_res_valid = 1'b1; sif.div_res_data = 32'hDEAD0003;
      end
    end
    pend = ((e_cnt > 0) ? 1 : 0) + ((a_cnt > 0) ? 1 : 0) + ((d_cnt > 0) ? 1 : 0);
    ops  = (sif.exp_op_valid ? 1 : 0) + (sif.add_op_valid ? 1 : 0) + (sif.div_op_valid ? 1 : 0);
    if (ops > 0) chk("one_outstanding", 32'(pend + ops), 32'd1);
    if (sif.exp_op_valid) begin
      if (ek < NC) chk("exp_op_data", sif.exp_op_data, x_exp[ek]);
      else chk("exp_extra", 32'(ek), 32'(NC - 1));
      e_pend = (g_real_exp != 0) ? r2f($exp(f2r(sif.exp_op_data))) : 32'h3F800000;
      e_cnt = pick_lat();
      ek++;
    end
    if (sif.add_op_valid) begin
      if (ak < NC) begin
        chk("add_op_a", sif.add_op_a, pre_exp[ak]);
        chk("add_op_b", sif.add_op_b, e_exp[ak]);
      end else chk("add_extra", 32'(ak), 32'(NC - 1));
      a_pend = r2f(f2r(sif.add_op_a) + f2r(sif.add_op_b));
      a_cnt = pick_lat();
      ak++;
    end
    if (sif.div_op_valid) begin
      if (dk < NC) begin
        chk("div_op_a", sif.div_op_a, e_exp[dk]);
        chk("div_op_b", sif.div_op_b, tot_exp);
      end else chk("div_extra", 32'(dk), 32'(NC - 1));
      d_pend = r2f(f2r(sif.div_op_a) / f2r(sif.div_op_b));
      d_cnt = pick_lat();
      dk++;
    end
    if (sif.out_valid) begin
      if (n_out < NC) begin
        chk("out_index", 32'(sif.out_index), 32'(n_out));
        chk("out_data", sif.out_data, p_exp[n_out]);
        p_sum += f2r(sif.out_data);
        out_e[n_out] = g_edge;
      end else chk("out_extra", 32'(n_out), 32'(NC - 1));
      n_out++;
    end
    if (done) begin
      chk("busy_at_done", 32'(busy), 32'd0);
      n_done++;
      done_e = g_edge;
    end
  end

  task automatic clear_counts();
    ek = 0; ak = 0; dk = 0; n_out = 0; n_done = 0; p_sum = 0.0;
  endtask

  task automatic run_frame(input string tag, input logic hold);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    clear_counts();
    start = 1'b1;
    t0 = g_edge;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (12) @(negedge clk);
    chk({tag, "_n_out"}, 32'(n_out), 32'(NC));
    chk({tag, "_n_done"}, 32'(n_done), 32'd1);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    golden_ones();
    clear_counts();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_exp_valid", 32'(sif.exp_op_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: constant exp, L=3
    g_lat = 3;
    run_frame("t1", 1'b0);

    // 2: L=1 timing
    g_lat = 1;
    run_frame("t2", 1'b0);
    chk("t2_first_lat", 32'(out_e[0] - t0), 32'd44);
    for (int i = 1; i < NC; i++) chk("t2_gap", 32'(out_e[i] - out_e[i-1]), 32'd2);
    chk("t2_done_lat", 32'(done_e - out_e[NC-1]), 32'd1);

    // 3: random latency with spurious strobes
    g_lat = 0; g_spur = 1;
    run_frame("t3", 1'b0);
    g_spur = 0;

    // 4: start held through a frame, then a fresh start
    g_lat = 2;
    run_frame("t4a", 1'b1);
    run_frame("t4b", 1'b0);

    // 5: reset while waiting on the adder
    g_lat = 3;
    @(negedge clk);
    clear_counts();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500 && ak < 3; c++) @(negedge clk);
    chk("t5_reached_acc", 32'(ak), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_add_valid", 32'(sif.add_op_valid), 32'd0);
    chk("t5_add_a", sif.add_op_a, 32'd0);
    chk("t5_add_b", sif.add_op_b, 32'd0);
    chk("t5_exp_data", sif.exp_op_data, 32'd0);
    chk("t5_div_b", sif.div_op_b, 32'd0);
    chk("t5_out_data", sif.out_data, 32'd0);
    chk("t5_out_index", 32'(sif.out_index), 32'd0);
    n_out = 0;
    repeat (12) @(negedge clk);
    chk("t5_no_out", 32'(n_out), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);
    chk("t5_no_add_op", 32'(ak), 32'd3);
    run_frame("t5b", 1'b0);

    // 6: real exp against the golden model
    golden_model();
    g_lat = 2;
    run_frame("t6", 1'b0);
    chk("t6_psum_near_1", 32'((p_sum > 0.999 && p_sum < 1.001) ? 1 : 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
